// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-state execute sequencer (IDLE/READ/EXEC/WB) wrapped around a combinational ALU.
// Ports: instr_valid/instr_ready/instr accept one decoded instruction; alu_ip_0/alu_ip_1/alu_opcode
// drive the ALU and alu_op_0/alu_change_pc return its result; pc is the program counter; done pulses
// in WB; dbg_addr/dbg_data give a combinational register-file read.
// Build option: define ALU_EXEC_ZERO_REG_EN to hardwire R[0] to zero.
module alu_exec_ctrl #(
  parameter int XLEN = 32,
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_ip_0,
  output logic [XLEN-1:0] alu_ip_1,
  output logic [2:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_op_0,
  input  logic            alu_change_pc,
  output logic [PC_W-1:0] pc,
  output logic            done,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
`ifdef ALU_EXEC_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [2:0] op_q, rd_q, rs_q, rt_q;
  logic imm_sel_q;
  logic [15:0] imm_q;
  logic [XLEN-1:0] regs [8];
  logic [XLEN-1:0] result, rs_val, rt_val, imm_x;
  logic taken, wr_en;
  logic unused_bits;
  assign unused_bits = ^instr[18:16];
  assign imm_x  = {{(XLEN-16){imm_q[15]}}, imm_q};
  assign rs_val = (ZERO_REG && rs_q == 3'd0) ? '0 : regs[rs_q];
  assign rt_val = (ZERO_REG && rt_q == 3'd0) ? '0 : regs[rt_q];
  assign dbg_data = (ZERO_REG && dbg_addr == 3'd0) ? '0 : regs[dbg_addr];
  // A taken branch suppresses the writeback; a zero-register build also drops writes to R[0].
  assign wr_en = state == WB && !taken && !(ZERO_REG && rd_q == 3'd0);
  // The encoding order makes WB+1 wrap back to IDLE.
  always_comb begin
    instr_ready = state == IDLE;
    done        = state == WB;
    state_nx    = state == IDLE ? (instr_valid ? READ : IDLE) : state_t'(state + 2'd1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
      alu_ip_0   <= '0;
      alu_ip_1   <= '0;
      alu_opcode <= '0;
      result     <= '0;
      taken      <= 1'b0;
      pc         <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instr_valid) begin
        op_q      <= instr[31:29];
        rd_q      <= instr[28:26];
        rs_q      <= instr[25:23];
        rt_q      <= instr[22:20];
        imm_sel_q <= instr[19];
        imm_q     <= instr[15:0];
      end
      if (state == READ) begin
        alu_ip_0   <= rs_val;
        alu_ip_1   <= imm_sel_q ? imm_x : rt_val;
        alu_opcode <= op_q;
      end
      if (state == EXEC) begin
        result <= alu_op_0;
        taken  <= alu_change_pc;
      end
      if (wr_en) regs[rd_q] <= result;
      if (state == WB) pc <= taken ? pc + imm_x[PC_W-1:0] : pc + PC_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: scoreboard bench for alu_exec_ctrl with a behavioural ALU.
module tb_alu_exec_ctrl;
`ifdef ALU_EXEC_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic instr_ready, alu_change_pc, done;
  logic [31:0] alu_ip_0, alu_ip_1, alu_op_0, dbg_data;
  logic [2:0] alu_opcode, dbg_addr = '0;
  logic [15:0] pc;
  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_ip_0(alu_ip_0), .alu_ip_1(alu_ip_1), .alu_opcode(alu_opcode), .alu_op_0(alu_op_0),
    .alu_change_pc(alu_change_pc), .pc(pc), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  assign alu_op_0      = alu_opcode == 3'd2 ? alu_ip_0 + alu_ip_1 : '0;
  assign alu_change_pc = alu_opcode == 3'd7 && alu_ip_0 == alu_ip_1;
  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  typedef struct {
    logic [2:0]  rd;
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_r [8];
  logic [15:0] m_pc;
  task automatic rd_dbg(input logic [2:0] a, input string tag, input logic [31:0] exp);
    dbg_addr = a;
    #1 check(tag, dbg_data, exp);
  endtask
  // Called just after a falling edge with the DUT in IDLE; returns in the same phase of cycle 4.
  task automatic issue(input logic [2:0] op, rd, rs, rt, input logic ui, input logic [15:0] imm);
    exp_t e;
    logic [31:0] a, b, res;
    logic tk;
    a   = m_r[rs];
    b   = ui ? {{16{imm[15]}}, imm} : m_r[rt];
    res = op == 3'd2 ? a + b : 32'd0;
    tk  = op == 3'd7 && a == b;
    e.rd = rd;
    e.old_v = m_r[rd];
    if (!tk && !(ZR && rd == 3'd0)) m_r[rd] = res;
    m_pc = tk ? m_pc + imm : m_pc + 16'd1;
    e.new_v = m_r[rd];
    e.pc = m_pc;
    sb.push_back(e);
    check("ready_idle", {31'd0, instr_ready}, 1);
    instr_valid = 1'b1;
    instr = {op, rd, rs, rt, ui, 3'b000, imm};
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '1;
    check("ready_read", {31'd0, instr_ready}, 0);
    check("done_read", {31'd0, done}, 0);
    @(negedge clk);
    check("ready_exec", {31'd0, instr_ready}, 0);
    check("done_exec", {31'd0, done}, 0);
    check("ip_0", alu_ip_0, a);
    check("ip_1", alu_ip_1, b);
    check("opcode", {29'd0, alu_opcode}, {29'd0, op});
    @(negedge clk);
    check("ready_wb", {31'd0, instr_ready}, 0);
    check("done_wb", {31'd0, done}, 1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      rd_dbg(e.rd, "dbg_prewrite", e.old_v);
      @(negedge clk);
      check("ready_next", {31'd0, instr_ready}, 1);
      check("done_clear", {31'd0, done}, 0);
      check("pc", {16'd0, pc}, {16'd0, e.pc});
      rd_dbg(e.rd, "dbg_postwrite", e.new_v);
    end else begin
      check("sb_pop", {31'd0, done}, 1);
      @(negedge clk);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0;
    #1;
    check("rst_ready", {31'd0, instr_ready}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pc", {16'd0, pc}, 0);
    check("rst_ip0", alu_ip_0, 0);
    check("rst_ip1", alu_ip_1, 0);
    check("rst_opc", {29'd0, alu_opcode}, 0);
    for (int i = 0; i < 8; i++) rd_dbg(3'(i), "rst_reg", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
    issue(3'd2, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0);
    issue(3'd7, 3'd7, 3'd1, 3'd1, 1'b0, 16'hFFFC);
    issue(3'd7, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0040);
    issue(3'd2, 3'd4, 3'd1, 3'd0, 1'b1, 16'hFFFF);
    issue(3'd2, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);
    rd_dbg(3'd0, "zero_reg", ZR ? 32'd0 : 32'h1234);
    issue(3'd2, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001);
    issue(3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 16'd0);
    instr_valid = 1'b1;
    instr = {3'd2, 3'd3, 3'd0, 3'd0, 1'b1, 3'b000, 16'd7};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0;
    #1;
    check("arst_ready", {31'd0, instr_ready}, 1);
    check("arst_pc", {16'd0, pc}, 0);
    check("arst_ip0", alu_ip_0, 0);
    repeat (2) begin
      @(negedge clk);
      check("arst_done", {31'd0, done}, 0);
    end
    rst_n = 1'b1;
    rd_dbg(3'd3, "arst_r3", 0);
    rd_dbg(3'd1, "arst_r1", 0);
    repeat (4) begin
      @(negedge clk);
      check("arst_idle_done", {31'd0, done}, 0);
      check("arst_idle_pc", {16'd0, pc}, 0);
    end
    issue(3'd2, 3'd3, 3'd0, 3'd0, 1'b1, 16'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
